// File: rtl/bp_fe_ras_ckpt_pkg.sv
// Shared types and helpers for the checkpointable return-address stack.
package bp_fe_ras_ckpt_pkg;

    // The single stack operation performed in a cycle, after priority resolution.
    typedef enum logic [2:0] {
        ras_op_none,
        ras_op_push,
        ras_op_pop,
        ras_op_push_pop,
        ras_op_restore
    } ras_op_e;

    // Resolve simultaneous requests: restore wins, then a combined push+pop
    // (replace top), then a lone push or pop. pop_v must already be qualified
    // by the stack being non-empty.
    function automatic ras_op_e ras_op_decode(input logic restore_v,
                                              input logic push_v,
                                              input logic pop_v);
        if (restore_v)
            return ras_op_restore;
        else if (push_v && pop_v)
            return ras_op_push_pop;
        else if (push_v)
            return ras_op_push;
        else if (pop_v)
            return ras_op_pop;
        else
            return ras_op_none;
    endfunction

    // Width of the flattened checkpoint {top_ptr, num_valid, top_pc}.
    function automatic int ras_ckpt_width(input int vaddr_width, input int num_entries);
        return $clog2(num_entries) + $clog2(num_entries + 1) + vaddr_width;
    endfunction

endpackage

// File: rtl/bp_fe_ras_ckpt_mem.sv
// Return-address storage: one write port, one asynchronous read port, no reset.
module bp_fe_ras_ckpt_mem #(
    parameter int width_p      = 39,
    parameter int els_p        = 8,
    localparam int addr_width_lp = $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem [els_p];

    // Single write per cycle; contents survive reset on purpose.
    always_ff @(posedge clk_i) begin
        if (w_v_i)
            mem[w_addr_i] <= w_data_i;
    end

    assign r_data_o = mem[r_addr_i];

endmodule

// File: rtl/bp_fe_ras_ckpt.sv
// Return-address stack with checkpoint/restore for front-end misprediction recovery.
module bp_fe_ras_ckpt
    import bp_fe_ras_ckpt_pkg::*;
#(
    parameter int vaddr_width_p       = 39,
    parameter int ras_num_entries_p   = 8,
    parameter int ras_overflow_drop_p = 0,
    localparam int ptr_width_lp  = $clog2(ras_num_entries_p),
    localparam int cnt_width_lp  = $clog2(ras_num_entries_p + 1),
    localparam int ckpt_width_lp = ras_ckpt_width(vaddr_width_p, ras_num_entries_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     push_v_i,
    input  logic [vaddr_width_p-1:0] push_pc_i,
    input  logic                     pop_ready_and_i,
    output logic [vaddr_width_p-1:0] pop_pc_o,
    output logic                     pop_v_o,
    output logic                     full_o,
    output logic [ckpt_width_lp-1:0] ckpt_o,
    input  logic                     restore_v_i,
    input  logic [ckpt_width_lp-1:0] restore_ckpt_i
);

    typedef struct packed {
        logic [ptr_width_lp-1:0]  top_ptr;
        logic [cnt_width_lp-1:0]  num_valid;
        logic [vaddr_width_p-1:0] top_pc;
    } bp_fe_ras_ckpt_s;

    localparam logic [cnt_width_lp-1:0] depth_lp = cnt_width_lp'(ras_num_entries_p);
    localparam bit drop_lp = (ras_overflow_drop_p != 0);

    logic [ptr_width_lp-1:0]  top_ptr, top_ptr_n;
    logic [cnt_width_lp-1:0]  num_valid, num_valid_n;
    logic                     w_v;
    logic [ptr_width_lp-1:0]  w_addr;
    logic [vaddr_width_p-1:0] w_data;
    logic [vaddr_width_p-1:0] r_data;
    bp_fe_ras_ckpt_s          restore_ckpt;
    bp_fe_ras_ckpt_s          cur_ckpt;
    ras_op_e                  op;

    assign restore_ckpt = bp_fe_ras_ckpt_s'(restore_ckpt_i);

    assign pop_v_o  = (num_valid != '0);
    assign full_o   = (num_valid == depth_lp);
    assign pop_pc_o = pop_v_o ? r_data : '0;

    assign cur_ckpt.top_ptr   = top_ptr;
    assign cur_ckpt.num_valid = num_valid;
    assign cur_ckpt.top_pc    = pop_pc_o;
    assign ckpt_o             = cur_ckpt;

    assign op = ras_op_decode(restore_v_i, push_v_i, pop_ready_and_i & pop_v_o);

    // Next pointer/count and the single entry write implied by this cycle's operation.
    always_comb begin
        top_ptr_n   = top_ptr;
        num_valid_n = num_valid;
        w_v         = 1'b0;
        w_addr      = top_ptr;
        w_data      = push_pc_i;
        unique case (op)
            ras_op_restore: begin
                top_ptr_n   = restore_ckpt.top_ptr;
                num_valid_n = restore_ckpt.num_valid;
                w_v         = (restore_ckpt.num_valid != '0);
                w_addr      = restore_ckpt.top_ptr;
                w_data      = restore_ckpt.top_pc;
            end
            ras_op_push_pop: begin
                w_v = 1'b1;
            end
            ras_op_push: begin
                if (!(full_o && drop_lp)) begin
                    w_v       = 1'b1;
                    w_addr    = top_ptr + 1'b1;
                    top_ptr_n = top_ptr + 1'b1;
                    if (!full_o)
                        num_valid_n = num_valid + 1'b1;
                end
            end
            ras_op_pop: begin
                top_ptr_n   = top_ptr - 1'b1;
                num_valid_n = num_valid - 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Pointer and occupancy registers; reset empties the stack but leaves storage alone.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            top_ptr   <= '0;
            num_valid <= '0;
        end else begin
            top_ptr   <= top_ptr_n;
            num_valid <= num_valid_n;
        end
    end

    bp_fe_ras_ckpt_mem #(
        .width_p (vaddr_width_p),
        .els_p   (ras_num_entries_p)
    ) mem (
        .clk_i    (clk_i),
        .w_v_i    (w_v & reset_n_i),
        .w_addr_i (w_addr),
        .w_data_i (w_data),
        .r_addr_i (top_ptr),
        .r_data_o (r_data)
    );

endmodule
